rename_table_ckpt: RTL
======================

// Module: rename_table_ckpt
// PURPOSE
//  Parametrised register rename table for the DP stage: per logical register holds busy bit + RRF tag.
//  Successor to the single-issue table: multi-port reads, DISP_W-wide dispatch allocation, COM_W-wide commit clear,
//  and CKPT_NUM branch checkpoints for single-cycle mispredict recovery. Feeds operand-source select (ARF vs RRF) to RS.
// PARAMETERS
//  REG_SEL   5  logical register index width
//  REG_NUM   32 number of logical registers (= 2**REG_SEL)
//  RRF_SEL   6  RRF tag width
//  NUM_RD    4  source read ports (2 per dispatch slot)
//  DISP_W    2  dispatch slots per cycle
//  COM_W     2  commit slots per cycle
//  CKPT_NUM  4  checkpoint slots; CKPT_SEL = $clog2(CKPT_NUM)
// PORTS
//  clk_i              in  1                   clock
//  reset_n_i          in  1                   asynchronous active-low reset
//  rs_i               in  NUM_RD*REG_SEL      source register indices, port p at [p*REG_SEL +: REG_SEL]
//  rs_busy_o          out NUM_RD              busy bit per read port
//  rs_rrftag_o        out NUM_RD*RRF_SEL      RRF tag per read port
//  disp_en_i          in  DISP_W              dispatch slot s allocates a destination
//  disp_dst_i         in  DISP_W*REG_SEL      destination logical register per slot
//  disp_tag_i         in  DISP_W*RRF_SEL      allocated RRF tag per slot
//  com_en_i           in  COM_W               commit slot c retires a destination write
//  com_dst_i          in  COM_W*REG_SEL       committed destination register
//  com_tag_i          in  COM_W*RRF_SEL       committed RRF tag
//  ckpt_save_i        in  1                   snapshot table into slot ckpt_save_id_i
//  ckpt_save_id_i     in  CKPT_SEL            checkpoint slot to write
//  ckpt_restore_i     in  1                   branch mispredict: restore from ckpt_restore_id_i
//  ckpt_restore_id_i  in  CKPT_SEL            checkpoint slot to restore
//  flush_all_i        in  1                   exception/full flush: clear every busy bit
// BEHAVIOUR
//  - Reset (reset_n_i=0, async): all busy, tag and checkpoint state = 0; rs_busy_o=0, rs_rrftag_o=0 while in reset.
//  - Reads: combinational from registered state, zero latency; no bypass of same-cycle dispatch/commit
//    (intra-bundle dependences resolved by dispatch logic). rs index 0 always returns busy=0, tag=0.
//  - Dispatch: for each disp_en_i[s] with disp_dst!=0: busy[dst]<=1, tag[dst]<=disp_tag. Same dst in several
//    slots in one cycle: highest slot index wins. dst==0 ignored.
//  - Commit: for each com_en_i[c]: clear busy[dst] only if com_tag == current tag[dst] and no dispatch slot
//    writes dst this cycle (dispatch set beats commit clear). Tag value untouched by commit.
//  - Next-state order: commit clear -> dispatch set -> (restore | flush_all) override.
//  - Checkpoint save: slot ckpt_save_id_i <= full next-state table (including this cycle's dispatch+commit).
//  - Live checkpoints: every commit clear condition is also applied to each checkpoint slot independently,
//    compared against that slot's own stored tag (keeps snapshots consistent with retirement).
//  - Restore: table <= checkpoint[ckpt_restore_id_i] with this cycle's commit clears applied; dispatch
//    writes ignored that cycle. Save and restore same cycle: restore wins, save dropped.
//  - flush_all_i: all busy <= 0 (tags kept); highest priority over restore, save and dispatch.
//  - Checkpoint allocation/freeing is owned by the branch tag manager; this block does not track validity.
//  - No handshake/backpressure: all inputs are qualified by their enables and accepted every cycle.
// STRUCTURE
//  - Shared package/Consts.vh: REG_SEL, REG_NUM, RRF_SEL, DISP_W, COM_W, CKPT_NUM defaults.
//  - Table state as packed {busy, tag} per register; one next-state function used by live and checkpoint copies.
//  - One sub-module: rename_table_ckpt_slot (one checkpoint copy: load, commit-clear, read-out); CKPT_NUM instances.
// TESTING
//  - Reset: assert reset_n_i mid-run after dispatching r5/tag 9 -> all rs_busy_o=0, tags 0, async without clock edge.
//  - Dispatch slot0 r3/tag4, slot1 r3/tag7 same cycle -> next cycle read r3: busy=1, tag=7; commit r3/tag4 -> stays busy.
//  - Commit r3/tag7 while slot0 dispatches r3/tag12 same cycle -> r3 busy=1, tag=12.
//  - Dispatch r1/tag2, save ckpt1, dispatch r1/tag5 + r2/tag6, restore ckpt1 -> r1 busy tag2, r2 not busy.
//  - Save ckpt0 with r4/tag3 busy, commit r4/tag3, restore ckpt0 -> r4 busy=0 (commit applied to snapshot).
//  - flush_all_i with 3 busy regs and simultaneous restore -> all busy=0; dispatch to r0 -> r0 never busy.

Source files
------------

// File: rtl/rename_table_ckpt_pkg.sv
// Shared sizing, table entry types and the commit-clear next-state function
// used by both the live rename table and every checkpoint copy.
package rename_table_ckpt_pkg;

    localparam int unsigned REG_SEL  = 5;
    localparam int unsigned REG_NUM  = 32;
    localparam int unsigned RRF_SEL  = 6;
    localparam int unsigned NUM_RD   = 4;
    localparam int unsigned DISP_W   = 2;
    localparam int unsigned COM_W    = 2;
    localparam int unsigned CKPT_NUM = 4;
    localparam int unsigned CKPT_SEL = $clog2(CKPT_NUM);

    typedef struct packed {
        logic               busy;
        logic [RRF_SEL-1:0] tag;
    } rt_entry_t;

    typedef rt_entry_t [REG_NUM-1:0] rt_table_t;

    // Clear busy where a commit matches the stored tag, unless hold[dst] protects it.
    function automatic rt_table_t commit_clear(
        input rt_table_t                  cur,
        input logic [COM_W-1:0]           en,
        input logic [COM_W*REG_SEL-1:0]   dst,
        input logic [COM_W*RRF_SEL-1:0]   tag,
        input logic [REG_NUM-1:0]         hold
    );
        rt_table_t nxt;
        nxt = cur;
        for (int c = 0; c < int'(COM_W); c++) begin
            if (en[c] &&
                cur[dst[c*REG_SEL +: REG_SEL]].tag == tag[c*RRF_SEL +: RRF_SEL] &&
                !hold[dst[c*REG_SEL +: REG_SEL]]) begin
                nxt[dst[c*REG_SEL +: REG_SEL]].busy = 1'b0;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rename_table_ckpt_slot.sv
// One branch checkpoint: loads a full table snapshot and keeps retiring
// commits against its own stored tags so a later restore is consistent.
module rename_table_ckpt_slot
    import rename_table_ckpt_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     load_i,
    input  rt_table_t                load_data_i,
    input  logic [COM_W-1:0]         com_en_i,
    input  logic [COM_W*REG_SEL-1:0] com_dst_i,
    input  logic [COM_W*RRF_SEL-1:0] com_tag_i,
    output rt_table_t                ckpt_next_c
);

    rt_table_t snap_q;

    // Snapshot with this cycle's commits applied; also the restore source.
    assign ckpt_next_c = commit_clear(snap_q, com_en_i, com_dst_i, com_tag_i, {REG_NUM{1'b0}});

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            snap_q <= '0;
        end else if (load_i) begin
            snap_q <= load_data_i;
        end else begin
            snap_q <= ckpt_next_c;
        end
    end

endmodule

// File: rtl/rename_table_ckpt.sv
// Rename table for the DP stage: busy bit + RRF tag per logical register,
// multi-port reads, wide dispatch/commit and branch checkpoints.
module rename_table_ckpt
    import rename_table_ckpt_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [NUM_RD*REG_SEL-1:0] rs_i,
    output logic [NUM_RD-1:0]         rs_busy_o,
    output logic [NUM_RD*RRF_SEL-1:0] rs_rrftag_o,
    input  logic [DISP_W-1:0]         disp_en_i,
    input  logic [DISP_W*REG_SEL-1:0] disp_dst_i,
    input  logic [DISP_W*RRF_SEL-1:0] disp_tag_i,
    input  logic [COM_W-1:0]          com_en_i,
    input  logic [COM_W*REG_SEL-1:0]  com_dst_i,
    input  logic [COM_W*RRF_SEL-1:0]  com_tag_i,
    input  logic                      ckpt_save_i,
    input  logic [CKPT_SEL-1:0]       ckpt_save_id_i,
    input  logic                      ckpt_restore_i,
    input  logic [CKPT_SEL-1:0]       ckpt_restore_id_i,
    input  logic                      flush_all_i
);

    rt_table_t            table_q;
    rt_table_t            table_cl;
    rt_table_t            table_disp;
    rt_table_t            table_d;
    rt_table_t            slot_next [CKPT_NUM];
    logic [REG_NUM-1:0]   disp_hit;
    logic [CKPT_NUM-1:0]  slot_load;

    // Registers written by dispatch this cycle; a dispatch set beats a commit clear.
    always_comb begin
        disp_hit = '0;
        for (int s = 0; s < int'(DISP_W); s++) begin
            if (disp_en_i[s] && disp_dst_i[s*REG_SEL +: REG_SEL] != '0) begin
                disp_hit[disp_dst_i[s*REG_SEL +: REG_SEL]] = 1'b1;
            end
        end
    end

    assign table_cl = commit_clear(table_q, com_en_i, com_dst_i, com_tag_i, disp_hit);

    // Ascending slot order so the highest slot wins on a duplicate destination.
    always_comb begin
        table_disp = table_cl;
        for (int s = 0; s < int'(DISP_W); s++) begin
            if (disp_en_i[s] && disp_dst_i[s*REG_SEL +: REG_SEL] != '0) begin
                table_disp[disp_dst_i[s*REG_SEL +: REG_SEL]].busy = 1'b1;
                table_disp[disp_dst_i[s*REG_SEL +: REG_SEL]].tag  = disp_tag_i[s*RRF_SEL +: RRF_SEL];
            end
        end
    end

    // Flush overrides restore, which overrides dispatch.
    always_comb begin
        table_d = table_disp;
        if (flush_all_i) begin
            table_d = table_q;
            for (int r = 0; r < int'(REG_NUM); r++) begin
                table_d[r].busy = 1'b0;
            end
        end else if (ckpt_restore_i) begin
            table_d = slot_next[ckpt_restore_id_i];
        end
    end

    always_comb begin
        slot_load = '0;
        if (ckpt_save_i && !ckpt_restore_i && !flush_all_i) begin
            slot_load[ckpt_save_id_i] = 1'b1;
        end
    end

    for (genvar k = 0; k < int'(CKPT_NUM); k++) begin : g_ckpt
        rename_table_ckpt_slot u_slot (
            .clk_i       (clk_i),
            .reset_n_i   (reset_n_i),
            .load_i      (slot_load[k]),
            .load_data_i (table_d),
            .com_en_i    (com_en_i),
            .com_dst_i   (com_dst_i),
            .com_tag_i   (com_tag_i),
            .ckpt_next_c (slot_next[k])
        );
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            table_q <= '0;
        end else begin
            table_q <= table_d;
        end
    end

    // Zero-latency reads from registered state; r0 is hardwired not-busy.
    always_comb begin
        rs_busy_o   = '0;
        rs_rrftag_o = '0;
        for (int p = 0; p < int'(NUM_RD); p++) begin
            if (rs_i[p*REG_SEL +: REG_SEL] != '0) begin
                rs_busy_o[p]                     = table_q[rs_i[p*REG_SEL +: REG_SEL]].busy;
                rs_rrftag_o[p*RRF_SEL +: RRF_SEL] = table_q[rs_i[p*REG_SEL +: REG_SEL]].tag;
            end
        end
    end

endmodule
